// File: rtl/divider.sv
// Iterative restoring divider: 2n-bit dividend by n-bit divisor, one quotient bit
// per clock, signed or unsigned per operation, behind a start/busy/done handshake.
`ifndef DEFAULT_WIDTH
`define DEFAULT_WIDTH 8
`endif

module divider #(
  parameter int unsigned n = `DEFAULT_WIDTH
) (
  input  logic           clk,
  input  logic           reset_n,
  input  logic           start,
  input  logic           sign,
  input  logic [2*n-1:0] dividend,
  input  logic [n-1:0]   divisor,
  output logic           busy,
  output logic           done,
  output logic [n-1:0]   quotient,
  output logic [n-1:0]   remainder,
  output logic           overflow,
  output logic           div_zero
);

  localparam int unsigned DW = 2 * n;
  localparam int unsigned CW = (n > 1) ? $clog2(n) : 1;
  localparam logic [CW-1:0] CNT_LAST = CW'(n - 1);
  localparam logic [n-1:0]  HALF     = {1'b1, {(n-1){1'b0}}};

  typedef enum logic [1:0] {IDLE, CALC, FIX} state_t;

  state_t        state;
  logic [n-1:0]  prem;       // partial remainder magnitude
  logic [n-1:0]  qacc;       // remaining dividend bits above, quotient bits shifting in below
  logic [n-1:0]  dvs;
  logic [n-1:0]  raw_lo;
  logic [CW-1:0] cnt;
  logic          sq;
  logic          sr;
  logic          sgn;
  logic          early_ovf;
  logic          early_dz;

  logic [DW-1:0] dvd_mag_c;
  logic [n-1:0]  dvs_mag_c;
  logic [n:0]    shifted_c;
  logic [n:0]    diff_c;
  logic          range_ovf_c;

  // Operand magnitudes, one trial subtraction, and the signed range check.
  always_comb begin
    dvd_mag_c   = (sign && dividend[DW-1]) ? DW'(-dividend) : dividend;
    dvs_mag_c   = (sign && divisor[n-1]) ? n'(-divisor) : divisor;
    shifted_c   = {prem, qacc[n-1]};
    diff_c      = shifted_c - {1'b0, dvs};
    range_ovf_c = sgn && (sq ? (qacc > HALF) : (qacc >= HALF));
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state     <= IDLE;
      busy      <= 1'b0;
      done      <= 1'b0;
      quotient  <= '0;
      remainder <= '0;
      overflow  <= 1'b0;
      div_zero  <= 1'b0;
      prem      <= '0;
      qacc      <= '0;
      dvs       <= '0;
      raw_lo    <= '0;
      cnt       <= '0;
      sq        <= 1'b0;
      sr        <= 1'b0;
      sgn       <= 1'b0;
      early_ovf <= 1'b0;
      early_dz  <= 1'b0;
    end else begin
      done <= 1'b0;
      case (state)
        IDLE: begin
          if (start) begin
            busy     <= 1'b1;
            overflow <= 1'b0;
            div_zero <= 1'b0;
            prem     <= dvd_mag_c[DW-1:n];
            qacc     <= dvd_mag_c[n-1:0];
            dvs      <= dvs_mag_c;
            raw_lo   <= dividend[n-1:0];
            sgn      <= sign;
            sq       <= sign & (dividend[DW-1] ^ divisor[n-1]);
            sr       <= sign & dividend[DW-1];
            cnt      <= CNT_LAST;
            // Quotient needs more than n bits (or divisor is zero): skip iteration.
            if ((divisor == '0) || (dvd_mag_c[DW-1:n] >= dvs_mag_c)) begin
              early_ovf <= 1'b1;
              early_dz  <= (divisor == '0);
              state     <= FIX;
            end else begin
              early_ovf <= 1'b0;
              early_dz  <= 1'b0;
              state     <= CALC;
            end
          end
        end
        CALC: begin
          if (!diff_c[n]) begin
            prem <= diff_c[n-1:0];
            qacc <= {qacc[n-2:0], 1'b1};
          end else begin
            prem <= shifted_c[n-1:0];
            qacc <= {qacc[n-2:0], 1'b0};
          end
          cnt <= cnt - CW'(1);
          if (cnt == '0) begin
            state <= FIX;
          end
        end
        FIX: begin
          if (early_ovf || range_ovf_c) begin
            quotient  <= '1;
            remainder <= raw_lo;
            overflow  <= 1'b1;
            div_zero  <= early_dz;
          end else begin
            quotient  <= sq ? n'(-qacc) : qacc;
            remainder <= sr ? n'(-prem) : prem;
            overflow  <= 1'b0;
            div_zero  <= 1'b0;
          end
          done  <= 1'b1;
          busy  <= 1'b0;
          state <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_divider.sv
// Bench for divider (n=8): table vectors and model-driven random operations feed a
// scoreboard that is checked on every done pulse, plus handshake and reset sequences.
module tb_divider;

  localparam int unsigned N = 8;

  logic         clk = 1'b0;
  logic         reset_n;
  logic         start;
  logic         sign;
  logic [2*N-1:0] dividend;
  logic [N-1:0] divisor;
  logic         busy;
  logic         done;
  logic [N-1:0] quotient;
  logic [N-1:0] remainder;
  logic         overflow;
  logic         div_zero;

  divider #(.n(N)) dut (
    .clk       (clk),
    .reset_n   (reset_n),
    .start     (start),
    .sign      (sign),
    .dividend  (dividend),
    .divisor   (divisor),
    .busy      (busy),
    .done      (done),
    .quotient  (quotient),
    .remainder (remainder),
    .overflow  (overflow),
    .div_zero  (div_zero)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic        sgn;
    logic [15:0] dvd;
    logic [7:0]  dvs;
    logic [7:0]  q;
    logic [7:0]  r;
    logic        ovf;
    logic        dz;
    int          lat;
    string       name;
  } vec_t;

  typedef struct {
    vec_t v;
    int   acc;
  } exp_t;

  exp_t sbq[$];
  int   checks   = 0;
  int   failures = 0;
  int   cyc      = 0;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] req);
    checks++;
    if (act !== req) begin
      failures++;
      $display("FAIL %s actual=%0h required=%0h", nm, act, req);
    end
  endtask

  // Reference: native integer division truncates toward zero, remainder follows dividend.
  function automatic vec_t model(input logic s, input logic [15:0] a, input logic [7:0] b);
    vec_t v;
    int sa, sb, qt, rt, qm;
    v.sgn = s; v.dvd = a; v.dvs = b; v.name = "rand";
    if (b == 8'h00) begin
      v.q = 8'hFF; v.r = a[7:0]; v.ovf = 1'b1; v.dz = 1'b1; v.lat = 1;
      return v;
    end
    sa = s ? int'($signed(a)) : int'(a);
    sb = s ? int'($signed(b)) : int'(b);
    qt = sa / sb;
    rt = sa % sb;
    qm = (qt < 0) ? -qt : qt;
    v.dz  = 1'b0;
    v.lat = (qm >= 256) ? 1 : 9;
    v.ovf = s ? ((qt < -128) || (qt > 127)) : (qt > 255);
    if (v.ovf) begin
      v.q = 8'hFF; v.r = a[7:0];
    end else begin
      v.q = 8'(qt); v.r = 8'(rt);
    end
    return v;
  endfunction

  // Scoreboard consumer: every done pulse must match the oldest outstanding request.
  always @(negedge clk) begin
    if (reset_n && done) begin
      if (sbq.size() == 0) begin
        chk("spurious_done", 32'(done), 32'd0);
      end else begin
        exp_t e;
        e = sbq.pop_front();
        chk({e.v.name, "_quotient"},  32'(quotient),  32'(e.v.q));
        chk({e.v.name, "_remainder"}, 32'(remainder), 32'(e.v.r));
        chk({e.v.name, "_overflow"},  32'(overflow),  32'(e.v.ovf));
        chk({e.v.name, "_div_zero"},  32'(div_zero),  32'(e.v.dz));
        chk({e.v.name, "_latency"},   32'(cyc - e.acc), 32'(e.v.lat));
        chk({e.v.name, "_busy_low"},  32'(busy),      32'd0);
      end
    end
  end

  // Called at a negedge; issues once the divider is idle (including a done cycle).
  task automatic issue(input vec_t v);
    int k = 0;
    while (busy && k < 100) begin
      @(negedge clk);
      k++;
    end
    if (k >= 100) chk({v.name, "_issue_timeout"}, 32'(busy), 32'd0);
    start    = 1'b1;
    sign     = v.sgn;
    dividend = v.dvd;
    divisor  = v.dvs;
    sbq.push_back('{v: v, acc: cyc + 1});
    @(negedge clk);
    start    = 1'b0;
    sign     = 1'($urandom);
    dividend = 16'($urandom);
    divisor  = 8'($urandom);
  endtask

  task automatic drain();
    int k = 0;
    while (sbq.size() != 0 && k < 200) begin
      @(negedge clk);
      k++;
    end
    if (sbq.size() != 0) chk("drain_timeout", 32'(sbq.size()), 32'd0);
    @(negedge clk);
  endtask

  vec_t tbl[13];
  vec_t va;
  vec_t vb;

  initial begin
    #500000;
    $display("FAIL watchdog expired checks=%0d", checks);
    $fatal(1, "watchdog");
  end

  initial begin
    tbl[0]  = '{1'b0, 16'h03E8, 8'h07, 8'h8E, 8'h06, 1'b0, 1'b0, 9, "u_1000_by_7"};
    tbl[1]  = '{1'b1, 16'hFF9C, 8'h07, 8'hF2, 8'hFE, 1'b0, 1'b0, 9, "s_m100_by_7"};
    tbl[2]  = '{1'b1, 16'hFF80, 8'h01, 8'h80, 8'h00, 1'b0, 1'b0, 9, "s_min_quot"};
    tbl[3]  = '{1'b1, 16'h0080, 8'h01, 8'hFF, 8'h80, 1'b1, 1'b0, 9, "s_range_ovf"};
    tbl[4]  = '{1'b0, 16'h1234, 8'h00, 8'hFF, 8'h34, 1'b1, 1'b1, 1, "div_by_zero"};
    tbl[5]  = '{1'b0, 16'h0700, 8'h07, 8'hFF, 8'h00, 1'b1, 1'b0, 1, "u_early_ovf"};
    tbl[6]  = '{1'b1, 16'h0064, 8'hF9, 8'hF2, 8'h02, 1'b0, 1'b0, 9, "s_100_by_m7"};
    tbl[7]  = '{1'b0, 16'hFFFF, 8'hFF, 8'hFF, 8'hFF, 1'b1, 1'b0, 1, "u_max_ovf"};
    tbl[8]  = '{1'b0, 16'hFEFF, 8'hFF, 8'hFF, 8'hFE, 1'b0, 1'b0, 9, "u_max_quot"};
    tbl[9]  = '{1'b1, 16'h0000, 8'h05, 8'h00, 8'h00, 1'b0, 1'b0, 9, "s_zero_dvd"};
    tbl[10] = '{1'b1, 16'hFF81, 8'hFF, 8'h7F, 8'h00, 1'b0, 1'b0, 9, "s_m127_by_m1"};
    tbl[11] = '{1'b1, 16'h0080, 8'hFF, 8'h80, 8'h00, 1'b0, 1'b0, 9, "s_128_by_m1"};
    tbl[12] = '{1'b1, 16'h8000, 8'h01, 8'hFF, 8'h00, 1'b1, 1'b0, 1, "s_early_ovf"};

    reset_n = 1'b0; start = 1'b0; sign = 1'b0; dividend = '0; divisor = '0;
    repeat (3) @(negedge clk);
    chk("rst_busy", 32'(busy), 32'd0);
    chk("rst_done", 32'(done), 32'd0);
    chk("rst_quotient", 32'(quotient), 32'd0);
    chk("rst_remainder", 32'(remainder), 32'd0);
    chk("rst_overflow", 32'(overflow), 32'd0);
    chk("rst_div_zero", 32'(div_zero), 32'd0);
    reset_n = 1'b1;
    @(negedge clk);

    // Table vectors issued back to back: each start lands in the previous done cycle.
    for (int i = 0; i < 13; i++) issue(tbl[i]);
    drain();

    for (int i = 0; i < 24; i++) begin
      logic        s;
      logic [15:0] a;
      logic [7:0]  b;
      s = 1'(i % 2);
      a = 16'($urandom) >> $urandom_range(0, 9);
      if (s && $urandom_range(0, 1) == 1) a = 16'(-a);
      b = (i == 7) ? 8'h00 : 8'($urandom);
      issue(model(s, a, b));
    end
    drain();

    // A start pulse mid-calculation is ignored.
    va = tbl[0];
    va.name = "ignore_start";
    issue(va);
    @(negedge clk);
    @(negedge clk);
    start = 1'b1; sign = 1'b1; dividend = 16'hFF9C; divisor = 8'h03;
    @(negedge clk);
    start = 1'b0;
    chk("busy_during_calc", 32'(busy), 32'd1);
    drain();
    repeat (12) @(negedge clk);

    // Start asserted during the done cycle is accepted with no bubble.
    va = tbl[1]; va.name = "b2b_first";
    vb = tbl[6]; vb.name = "b2b_second";
    issue(va);
    issue(vb);
    drain();

    // Reset mid-calculation clears everything without a done pulse.
    va = tbl[8]; va.name = "reset_mid";
    issue(va);
    repeat (3) @(negedge clk);
    reset_n = 1'b0;
    #1;
    sbq.delete();
    chk("midrst_busy", 32'(busy), 32'd0);
    chk("midrst_done", 32'(done), 32'd0);
    chk("midrst_quotient", 32'(quotient), 32'd0);
    chk("midrst_remainder", 32'(remainder), 32'd0);
    chk("midrst_overflow", 32'(overflow), 32'd0);
    chk("midrst_div_zero", 32'(div_zero), 32'd0);
    @(negedge clk);
    reset_n = 1'b1;
    repeat (15) @(negedge clk);
    chk("post_rst_idle", 32'(busy), 32'd0);

    issue(tbl[1]);
    drain();

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
